// File: rtl/fir_pkg.sv
// Shared FIR definitions: widths, plus the rounding/saturation helper used by the
// decimation buffer and by its bench model.
package fir_pkg;

    localparam int FIR_WIDTH = 8;
    localparam int ACC_WIDTH = 2 * FIR_WIDTH;

    typedef struct packed {
        logic        sat;
        logic [31:0] word;
    } rs_t;

    // Round half-up by 2^(shift-1), shift right, clamp to an unsigned width-bit word.
    function automatic rs_t round_sat(input logic [31:0] x, input int width, input int shift);
        logic [32:0] rnd;
        logic [32:0] q;
        logic [32:0] maxv;
        rs_t         r;
        rnd  = {1'b0, x} + (33'd1 << (shift - 1));
        q    = rnd >> shift;
        maxv = (33'd1 << width) - 33'd1;
        if (q > maxv) begin
            r.sat  = 1'b1;
            r.word = maxv[31:0];
        end else begin
            r.sat  = 1'b0;
            r.word = q[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry sits in an output register that
// updates one edge after a push and holds the last popped entry while empty.
module fir_sync_fifo_fwft #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [LW-1:0]     remain;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = dout_q;

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        remain   = level_q - LW'(pop_ok);
        level_d  = remain + LW'(push_ok);
        dout_d   = dout_q;
        // With nothing left behind the popped head, the new head is the word being pushed.
        if (level_d != '0) begin
            dout_d = (remain == '0) ? din : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps every DECIM-th qualified fir_out sample, rounds/saturates it to WIDTH bits
// and queues it for a valid/ready consumer, flagging dropped samples stickily.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DECIM = 2,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*WIDTH-1:0]         fir_out,
    input  logic                       sample_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_sat,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int LW   = $clog2(DEPTH+1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             stage_valid_q, stage_valid_d;
    logic [WIDTH-1:0] stage_word_q, stage_word_d;
    logic             stage_sat_q, stage_sat_d;
    logic             overflow_q, overflow_d;
    rs_t              rs;
    logic             keep;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   fifo_dout;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        rs   = round_sat(32'(fir_out), WIDTH, SHIFT);
        keep = sample_en && (phase_q == '0);

        phase_d = phase_q;
        if (sample_en) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end

        stage_valid_d = keep;
        stage_word_d  = stage_word_q;
        stage_sat_d   = stage_sat_q;
        if (keep) begin
            stage_word_d = rs.word[WIDTH-1:0];
            // Any nonzero bit above the word is treated as saturation as well.
            stage_sat_d  = rs.sat || (rs.word[31:WIDTH] != '0);
        end

        pop  = !fifo_empty && dout_ready;
        push = stage_valid_q && (!fifo_full || pop);

        overflow_d = overflow_q;
        if (stage_valid_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_word_q  <= '0;
            stage_sat_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= stage_valid_d;
            stage_word_q  <= stage_word_d;
            stage_sat_q   <= stage_sat_d;
            overflow_q    <= overflow_d;
        end
    end

    fir_sync_fifo_fwft #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({stage_sat_q, stage_word_q}),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dout       = fifo_dout[WIDTH-1:0];
    assign dout_sat   = fifo_dout[WIDTH];
    assign dout_valid = !fifo_empty;
    assign level      = fifo_level;
    assign overflow   = overflow_q;

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
Downstream stage of fir_filter. Consumes the 2*WIDTH-bit fir_out stream and keeps every DECIM-th qualified sample. Each kept sample is rounded and shifted right by SHIFT, then saturated to WIDTH bits. Results are buffered in a small first-word-fall-through FIFO and presented to the next consumer over a valid/ready handshake, with sticky overflow reporting.

Parameters:
WIDTH, 8, fir_filter data width; fir_out is 2*WIDTH bits, dout is WIDTH bits
DECIM, 2, decimation ratio (>=1); 1 keeps every qualified sample
SHIFT, 8, right-shift applied to fir_out (1..WIDTH), with round-half-up
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fir_out  in  2*WIDTH  fir_filter output sample (unsigned)
sample_en  in  1  fir_out is valid this cycle
dout  out  WIDTH  head-of-FIFO result
dout_sat  out  1  head result was saturated
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer accepts head
level  out  $clog2(DEPTH+1)  FIFO occupancy
overflow  out  1  sticky: a kept sample was dropped
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release): dout=0, dout_sat=0, dout_valid=0, level=0, overflow=0. Phase counter=0, stage valid=0. FIFO contents are discarded, including on reset mid-operation.
- Phase counter:
  - Advances mod DECIM only on edges where sample_en=1.
  - A sample is kept when sample_en=1 and phase==0, so the first qualified sample after reset is kept.
  - sample_en=0 cycles change nothing.
- Arithmetic (unsigned):
  - rnd = fir_out + 2^(SHIFT-1), computed in 2*WIDTH+1 bits; q = rnd >> SHIFT.
  - If q > 2^WIDTH-1: word = all ones, sat=1. Else word = q[WIDTH-1:0], sat=0.
- Pipeline:
  - The kept sample's word and sat are registered into the stage register at edge N (stage valid=1).
  - The push into the FIFO happens at edge N+1.
  - If the FIFO was empty, dout_valid=1 and dout shows the word after edge N+1. Latency is 2 cycles; throughput is 1 sample per cycle when DECIM=1.
- FIFO (FWFT, WIDTH+1 bits per entry):
  - pop = dout_valid && dout_ready.
  - push = stage valid && (level<DEPTH || pop).
  - Full and no pop: the stage word is dropped and overflow is set at that edge.
  - Full with simultaneous push and pop: both occur, level stays DEPTH, no overflow.
  - Empty: no pop is possible and there is no same-cycle bypass; data is always visible one edge after the push.
  - Read/write pointers wrap mod DEPTH. level is exact at all times.
- dout/dout_sat: when dout_valid=0 they hold the last popped entry (0 after reset). Never X.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it at the next edge.
- dout_ready=1 while empty has no effect.

Decomposition:
- Shared package fir_pkg: FIR_WIDTH=8, ACC_WIDTH=2*FIR_WIDTH, and a round/saturate function (used here and by the bench model).
- One sub-module: fir_sync_fifo_fwft.
  - Parameters: DATA_W, DEPTH.
  - Ports: push, pop, din, dout, level, full, empty.
- Phase counter, round/saturate stage and overflow logic stay in fir_decim_buffer.

Test Plan:
1. Rounding (DECIM=1, SHIFT=8, ready=1): fir_out 0x017F then 0x0180 with sample_en=1 -> dout 0x01 then 0x02, both sat=0. Each appears 2 cycles after its sample edge.
2. Saturation: fir_out 0xFF7F -> dout 0xFF, sat=0. fir_out 0xFF80 -> dout 0xFF, sat=1.
3. Decimation (DECIM=2): ramp 0x0000, 0x0100, 0x0200, 0x0300, 0x0400 with sample_en=1 -> dout 0x00, 0x02, 0x04.
   - Repeat with sample_en=0 bubbles inserted -> same outputs, phase unchanged during bubbles.
4. Backpressure/overflow (DECIM=1, ready=0):
   - Push 5 samples 0x0100..0x0500 -> level=4, overflow=1, dout=0x01.
   - Then ready=1 -> 0x01, 0x02, 0x03, 0x04 drained in order; 0x05 lost; level returns to 0.
   - Then pulse ovf_clr -> overflow=0.
5. Full plus simultaneous pop: level=4, stage valid, ready=1 -> level stays 4, overflow stays 0, order preserved.
   - Separately, ovf_clr asserted in the same cycle as a drop -> overflow=1.
6. Reset mid-op: level=3, drop rst_n between edges -> dout_valid, level, overflow, dout go 0 immediately.
   - After release, the first qualified sample is kept (phase=0).
